// File: rtl/mux_scan_sequencer.sv
// Round-robin scan controller for an 8:1 channel mux: settles on each enabled
// channel, samples mux_in and emits the sample on a valid/ready stream.
module mux_scan_sequencer #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NCH-1:0]     mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [WIDTH-1:0]   mux_in,
    output logic [2:0]         Sel,
    output logic [WIDTH-1:0]   dout,
    output logic [2:0]         dout_ch,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               busy
);

    localparam int SELW = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [NCH-1:0]     mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic               stop_pend;

    logic               slot_free;
    logic               start_ok;
    logic               capture;
    logic               stop_eff;
    logic [DWELL_W-1:0] dwell_eff;
    logic [SELW-1:0]    first_sel;
    logic [SELW-1:0]    next_sel;

    assign busy      = (state != S_IDLE);
    assign slot_free = !dout_valid || dout_ready;
    assign start_ok  = start && (mask != '0);
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    // A stop arriving on the capture edge itself ends the scan at that capture.
    assign stop_eff  = stop_pend || stop;

    always_comb begin
        first_sel = '0;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (mask[i-1]) first_sel = SELW'(i-1);
        end
    end

    // Offset NCH wraps back to Sel itself, so a single-channel mask re-selects it.
    always_comb begin
        next_sel = Sel;
        for (int unsigned i = NCH; i > 0; i--) begin
            if (mask_q[Sel + SELW'(i)]) next_sel = Sel + SELW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == DWELL_W'(1)) begin
                    if (slot_free) capture = 1'b1;
                    else           state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (slot_free) capture = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (capture) state_nxt = stop_eff ? S_IDLE : S_SETTLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sel        <= '0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            stop_pend  <= 1'b0;
            mask_q     <= '0;
            dwell_q    <= '0;
            cnt        <= '0;
        end else begin
            if (state == S_IDLE && start_ok) begin
                mask_q  <= mask;
                dwell_q <= dwell_eff;
                Sel     <= first_sel;
                cnt     <= dwell_eff;
            end
            if (state == S_SETTLE) cnt <= cnt - DWELL_W'(1);

            if (capture) begin
                dout       <= mux_in;
                dout_ch    <= Sel;
                dout_valid <= 1'b1;
                stop_pend  <= 1'b0;
                if (!stop_eff) begin
                    Sel <= next_sel;
                    cnt <= dwell_q;
                end
            end else begin
                if (dout_ready) dout_valid <= 1'b0;
                if (busy && stop) stop_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer; expected values are hand-derived
// cycle by cycle from the start edge (E0) of each scan.
module tb_mux_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] mask;
    logic [3:0] dwell;
    logic [7:0] mux_in;
    logic [2:0] Sel;
    logic [7:0] dout;
    logic [2:0] dout_ch;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    mux_scan_sequencer #(.WIDTH(8), .NCH(8), .DWELL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .dwell      (dwell),
        .mux_in     (mux_in),
        .Sel        (Sel),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    // Mux model: channel i presents 8'h10 + i.
    assign mux_in = 8'h10 + {5'b0, Sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge just after the start edge E0.
    task automatic do_start(input logic [7:0] m, input logic [3:0] d, input logic with_stop);
        @(negedge clk);
        mask  = m;
        dwell = d;
        start = 1'b1;
        stop  = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop       = 1'b0;
        dout_ready = 1'b1;
        for (int k = 0; k < 60 && (busy || dout_valid); k++) @(negedge clk);
        check("drain_idle", {busy, dout_valid}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        mask = '0; dwell = '0; dout_ready = 1'b0;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_sel", Sel, 0);
        check("rst_dout", dout, 0);
        check("rst_ch", dout_ch, 0);
        rst_n = 1'b1;

        // T2 full scan, dwell 0 behaves as 1
        dout_ready = 1'b1;
        do_start(8'hFF, 4'd0, 1'b0);
        check("t2_busy", busy, 1);
        check("t2_sel0", Sel, 0);
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            check("t2_ch", dout_ch, (k - 1) % 8);
            check("t2_dout", dout, 8'h10 + ((k - 1) % 8));
            check("t2_valid", dout_valid, 1);
        end
        drain();

        // T3 sparse mask, dwell 3; stop together with start is ignored
        do_start(8'h24, 4'd3, 1'b1);
        check("t3_sel_e0", Sel, 2);
        check("t3_valid_e0", dout_valid, 0);
        tick(2);
        check("t3_valid_e2", dout_valid, 0);
        tick(1);
        check("t3_valid_e3", dout_valid, 1);
        check("t3_ch_e3", dout_ch, 2);
        check("t3_dout_e3", dout, 8'h12);
        check("t3_sel_e3", Sel, 5);
        check("t3_busy_e3", busy, 1);
        tick(1);
        check("t3_valid_e4", dout_valid, 0);
        tick(2);
        check("t3_ch_e6", dout_ch, 5);
        check("t3_dout_e6", dout, 8'h15);
        check("t3_sel_e6", Sel, 2);
        tick(3);
        check("t3_ch_e9", dout_ch, 2);
        tick(3);
        check("t3_ch_e12", dout_ch, 5);
        drain();

        // T4 backpressure
        dout_ready = 1'b0;
        do_start(8'h03, 4'd1, 1'b0);
        check("t4_sel_e0", Sel, 0);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check("t4_hold_ch", dout_ch, 0);
            check("t4_hold_dout", dout, 8'h10);
            check("t4_hold_valid", dout_valid, 1);
            check("t4_hold_sel", Sel, 1);
        end
        dout_ready = 1'b1;
        tick(1);
        check("t4_ch_e6", dout_ch, 1);
        check("t4_dout_e6", dout, 8'h11);
        check("t4_valid_e6", dout_valid, 1);
        check("t4_sel_e6", Sel, 0);
        tick(1);
        check("t4_ch_e7", dout_ch, 0);
        check("t4_sel_e7", Sel, 1);
        drain();

        // T5 stop mid-settle on ch4
        dout_ready = 1'b1;
        do_start(8'h30, 4'd4, 1'b0);
        check("t5_sel_e0", Sel, 4);
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("t5_busy_e2", busy, 1);
        tick(1);
        check("t5_busy_e3", busy, 1);
        check("t5_valid_e3", dout_valid, 0);
        tick(1);
        check("t5_busy_e4", busy, 0);
        check("t5_valid_e4", dout_valid, 1);
        check("t5_ch_e4", dout_ch, 4);
        check("t5_dout_e4", dout, 8'h14);
        check("t5_sel_e4", Sel, 4);
        tick(1);
        check("t5_valid_e5", dout_valid, 0);
        tick(3);
        check("t5_busy_late", busy, 0);
        check("t5_valid_late", dout_valid, 0);
        check("t5_sel_late", Sel, 4);

        // T6 illegal start, then mask change and start while busy mid-scan
        do_start(8'h00, 4'd2, 1'b0);
        check("t6_busy_e0", busy, 0);
        tick(2);
        check("t6_busy_e2", busy, 0);
        check("t6_valid_e2", dout_valid, 0);
        do_start(8'h81, 4'd0, 1'b0);
        check("t6_sel_e0", Sel, 0);
        mask  = 8'hFF;
        dwell = 4'd5;
        tick(1);
        check("t6_sel_e1", Sel, 7);
        check("t6_ch_e1", dout_ch, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t6_sel_e2", Sel, 0);
        check("t6_ch_e2", dout_ch, 7);
        check("t6_dout_e2", dout, 8'h17);
        tick(1);
        check("t6_sel_e3", Sel, 7);
        drain();

        // T1 async reset while busy with a pending sample
        dout_ready = 1'b0;
        do_start(8'hFF, 4'd0, 1'b0);
        tick(2);
        check("t1_busy_pre", busy, 1);
        check("t1_valid_pre", dout_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_busy", busy, 0);
        check("t1_valid", dout_valid, 0);
        check("t1_sel", Sel, 0);
        check("t1_dout", dout, 0);
        check("t1_ch", dout_ch, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        tick(2);
        check("t1_busy_post", busy, 0);
        check("t1_valid_post", dout_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
